// File: rtl/instrumented_adder_sequencer.sv
// Measurement sequencer for the instrumented adder macros: drives operands, enables one ring
// oscillator, counts its edges over a clock window and captures the sum. Define INSTR_ADDER_FORMAL_EN for embedded assertions.
module instrumented_adder_sequencer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int WINDOW_W = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          start,
  input  logic [$clog2(CHANNELS)-1:0]   chan_sel,
  input  logic [WINDOW_W-1:0]           window,
  input  logic [WIDTH-1:0]              a_in,
  input  logic [WIDTH-1:0]              b_in,
  input  logic [WIDTH-1:0]              bypass_in,
  input  logic [CHANNELS-1:0]           ro_in,
  input  logic [CHANNELS*WIDTH-1:0]     s_in,
  output logic [WIDTH-1:0]              adder_a,
  output logic [WIDTH-1:0]              adder_b,
  output logic [WIDTH-1:0]              bypass_out,
  output logic [CHANNELS-1:0]           ro_en,
  output logic [CNT_W-1:0]              count,
  output logic [WIDTH-1:0]              s_out,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [CHANNELS-1:0] ONE_HOT0 = {{(CHANNELS-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_W-1:0] WIN_ONE  = {{(WINDOW_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ARM0    = 3'd2,
    ARM1    = 3'd3,
    COUNT   = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CH_W-1:0]     chan_r;
  logic [CH_W-1:0]     chan_load_s;
  logic [CH_W-1:0]     chan_d_s;
  logic [WINDOW_W-1:0] win_cnt_r;
  logic                sync1_r;
  logic                sync2_r;
  logic                prev_r;
  logic [WIDTH-1:0]    sum_s [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_sum
    assign sum_s[k] = s_in[k*WIDTH +: WIDTH];
  end

  // Channel decode: out-of-range selects fall back to channel 0; the synchroniser follows the
  // incoming channel already on the LOAD edge so ARM leaves it fully primed.
  always_comb begin
    chan_load_s = {CH_W{1'b0}};
    chan_d_s    = chan_r;
    if (32'(chan_sel) < 32'(CHANNELS)) begin
      chan_load_s = chan_sel;
    end else begin
      chan_load_s = {CH_W{1'b0}};
    end
    if (state_r == LOAD) begin
      chan_d_s = chan_load_s;
    end else begin
      chan_d_s = chan_r;
    end
  end

  // Next-state logic of the measurement sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LOAD; else state_s = IDLE;
      LOAD:    if (window == {WINDOW_W{1'b0}}) state_s = CAPTURE; else state_s = ARM0;
      ARM0:    state_s = ARM1;
      ARM1:    state_s = COUNT;
      COUNT:   if (win_cnt_r == WIN_ONE) state_s = CAPTURE; else state_s = COUNT;
      CAPTURE: state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, ring synchroniser and all registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= IDLE;
      chan_r     <= {CH_W{1'b0}};
      win_cnt_r  <= {WINDOW_W{1'b0}};
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      prev_r     <= 1'b0;
      adder_a    <= {WIDTH{1'b0}};
      adder_b    <= {WIDTH{1'b0}};
      bypass_out <= {WIDTH{1'b0}};
      ro_en      <= {CHANNELS{1'b0}};
      count      <= {CNT_W{1'b0}};
      s_out      <= {WIDTH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_r <= state_s;
      sync1_r <= ro_in[chan_d_s];
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      done    <= 1'b0;
      case (state_r)
        LOAD: begin
          adder_a    <= a_in;
          adder_b    <= b_in;
          bypass_out <= bypass_in;
          chan_r     <= chan_load_s;
          win_cnt_r  <= window;
          count      <= {CNT_W{1'b0}};
          overflow   <= 1'b0;
          busy       <= 1'b1;
          if (window != {WINDOW_W{1'b0}}) ro_en <= ONE_HOT0 << chan_load_s;
          else ro_en <= {CHANNELS{1'b0}};
        end
        COUNT: begin
          win_cnt_r <= win_cnt_r - WIN_ONE;
          if (sync2_r && !prev_r) begin
            if (count == CNT_MAX) overflow <= 1'b1;
            else count <= count + CNT_ONE;
          end
          // Ring switches off as the last window cycle ends.
          if (win_cnt_r == WIN_ONE) ro_en <= {CHANNELS{1'b0}};
        end
        CAPTURE: begin
          ro_en <= {CHANNELS{1'b0}};
          s_out <= sum_s[chan_r];
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INSTR_ADDER_FORMAL_EN
  a_ro_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) $onehot0(ro_en));
  a_done_pulse: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) done |=> !done);
  a_busy_done: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) !(busy && done));
  a_count_mono: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    (busy && $past(state_r) != LOAD) |-> (count >= $past(count)));
  a_ovf_max: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i) overflow |-> (count == CNT_MAX));
  c_done_cnt: cover property (@(posedge wb_clk_i) disable iff (wb_rst_i) done && (count != {CNT_W{1'b0}}));
  c_done_ovf: cover property (@(posedge wb_clk_i) disable iff (wb_rst_i) done && overflow);
`else
  // Default build carries no checking logic.
`endif

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Scoreboard bench for instrumented_adder_sequencer: expectations are queued at start and
// compared when done pulses; a second instance with CNT_W=4 exercises saturation.
module tb_instrumented_adder_sequencer;
  localparam int W = 32;
  localparam int CH = 4;
  localparam int WW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            start2 = 1'b0;
  logic [1:0]      chan_sel = 2'd0;
  logic [WW-1:0]   window = 16'd0;
  logic [W-1:0]    a_in = 32'd0, b_in = 32'd0, bypass_in = 32'd0;
  logic [CH-1:0]   ro_in = 4'd0;
  logic [CH*W-1:0] s_in, s_in2;
  logic [W-1:0]    adder_a, adder_b, bypass_out, s_out;
  logic [W-1:0]    adder_a2, adder_b2, bypass_out2, s_out2;
  logic [CH-1:0]   ro_en, ro_en2;
  logic [31:0]     count;
  logic [3:0]      count2;
  logic            busy, done, overflow, busy2, done2, overflow2;

  instrumented_adder_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .chan_sel(chan_sel), .window(window),
    .a_in(a_in), .b_in(b_in), .bypass_in(bypass_in), .ro_in(ro_in), .s_in(s_in),
    .adder_a(adder_a), .adder_b(adder_b), .bypass_out(bypass_out), .ro_en(ro_en),
    .count(count), .s_out(s_out), .busy(busy), .done(done), .overflow(overflow));

  instrumented_adder_sequencer #(.CNT_W(4)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .chan_sel(chan_sel), .window(window),
    .a_in(a_in), .b_in(b_in), .bypass_in(bypass_in), .ro_in(ro_in), .s_in(s_in2),
    .adder_a(adder_a2), .adder_b(adder_b2), .bypass_out(bypass_out2), .ro_en(ro_en2),
    .count(count2), .s_out(s_out2), .busy(busy2), .done(done2), .overflow(overflow2));

  // Adder models: every channel computes a + b of its operands.
  for (genvar k = 0; k < CH; k++) begin : g_add
    assign s_in[k*W +: W]  = adder_a + adder_b;
    assign s_in2[k*W +: W] = adder_a2 + adder_b2;
  end

  typedef struct {
    logic [31:0] cnt;
    logic        ovf;
    logic [31:0] s;
    logic [31:0] a;
    logic [31:0] byp;
    int          done_cyc;
    int          ro_hi;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ro_hi = 0;
  int          ph = 0;
  int          ro_mode = 0;
  logic [3:0]  exp_ro = 4'd0;
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ring oscillator stimulus, changing away from the sampling edge.
  always @(negedge clk) begin
    ph = ph + 1;
    case (ro_mode)
      1: ro_in = {4'(((ph / 2) % 2) << 3) | 4'(((ph / 5) % 2) << 2) |
                  4'(((ph / 3) % 2) << 1) | 4'(ph % 2)};
      2: ro_in = {3'd0, 1'(ph % 2)};
      default: ro_in = 4'd0;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: ring enable shape, done pulse shape and scoreboard compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (ro_en != 4'd0) begin
        ro_hi = ro_hi + 1;
        check_val("ro_en_onehot", ro_en, exp_ro);
      end
      if (done_prev) check_val("done_pulse", done, 1'b0);
      if (done) begin
        check_val("busy_at_done", busy, 1'b0);
        if (q.size() == 0) begin
          check_val("unexpected_done", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_val("done_cycle", cyc, e.done_cyc);
          check_val("count", count, e.cnt);
          check_val("overflow", overflow, e.ovf);
          check_val("s_out", s_out, e.s);
          check_val("adder_a", adder_a, e.a);
          check_val("bypass_out", bypass_out, e.byp);
          check_val("ro_en_cycles", ro_hi, e.ro_hi);
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic run(input logic [1:0] ch, input int win, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ecnt, input logic eovf);
    exp_t e;
    @(negedge clk);
    chan_sel = ch; window = 16'(win); a_in = a; b_in = b; bypass_in = a ^ b;
    exp_ro = 4'd1 << ch;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.cnt = ecnt; e.ovf = eovf; e.s = a + b; e.a = a; e.byp = a ^ b;
    e.done_cyc = cyc + ((win == 0) ? 3 : 5 + win);
    e.ro_hi = (win == 0) ? 0 : win + 2;
    ro_hi = 0;
    q.push_back(e);
    @(negedge clk);
    a_in = $urandom; b_in = $urandom; bypass_in = $urandom;
    chan_sel = 2'($urandom_range(0, 3)); window = 16'($urandom_range(0, 9));
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check_val("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
    check_val({tag, "_ovf"}, overflow, 1'b0);
    check_val({tag, "_count"}, count, 32'd0);
    check_val({tag, "_s_out"}, s_out, 32'd0);
    check_val({tag, "_a"}, {adder_a, adder_b}, 64'd0);
    check_val({tag, "_byp"}, bypass_out, 32'd0);
    check_val({tag, "_ro_en"}, ro_en, 4'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int t0;
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    check_val("reset_dut2", {busy2, done2, overflow2, count2, ro_en2}, 64'd0);

    // Channel 1, period-6 ring among other toggling rings.
    ro_mode = 1;
    ra = $urandom; rb = $urandom;
    run(2'd1, 60, ra, rb, 32'd10, 1'b0);
    wait_empty(200);

    // Zero window: straight to capture, ring never enabled.
    ro_mode = 0;
    run(2'd2, 0, 32'h1234_5678, 32'h0000_1111, 32'd0, 1'b0);
    wait_empty(50);

    // Sum capture including carry-out wrap.
    run(2'd3, 8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    wait_empty(50);
    run(2'd3, 8, 32'd5, 32'd7, 32'd0, 1'b0);
    wait_empty(50);
    check_val("s_out_hold", s_out, 32'h0000_000C);

    // Saturation on the 4-bit counter instance.
    ro_mode = 2;
    @(negedge clk);
    chan_sel = 2'd0; window = 16'd40; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    check_val("dut2_done_seen", seen, 1'b1);
    check_val("dut2_done_cycle", cyc, t0 + 45);
    check_val("dut2_count", count2, 4'd15);
    check_val("dut2_overflow", overflow2, 1'b1);
    @(negedge clk);
    check_val("dut2_done_pulse", done2, 1'b0);
    check_val("dut2_hold", {count2, overflow2}, {4'd15, 1'b1});

    // Reset in the middle of COUNT aborts the measurement.
    ro_mode = 1;
    run(2'd1, 60, 32'hA5A5_0000, 32'h0000_5A5A, 32'd10, 1'b0);
    repeat (12) @(negedge clk);
    check_val("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_ro = 4'd0;
    check_all_zero("mid_reset");
    repeat (80) @(negedge clk);
    check_val("mid_reset_idle", busy, 1'b0);

    // Start pulsed while busy must be ignored: exactly one done.
    ra = $urandom; rb = $urandom;
    run(2'd2, 20, ra, rb, 32'd2, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty(100);
    repeat (40) @(negedge clk);
    check_val("busy_after_ignore", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/instrumented_adder_sequencer.md
Name: instrumented_adder_sequencer

Overview:
- Parametrised measurement controller for the instrumented adder macros.
- Drives shared operands and the ring-bypass mask to CHANNELS adder instances.
- Enables exactly one ring oscillator and counts its rising edges over a programmable clock window.
- Captures the selected adder's sum and raises a done handshake; results go out on the logic-analyser bus.

Parameters:
- WIDTH, 32, adder operand/sum width
- CHANNELS, 4, number of adder instances under test (must be >= 2)
- CNT_W, 32, edge-counter width
- WINDOW_W, 16, measurement-window counter width

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- start  in  1  request a measurement; sampled only in IDLE
- chan_sel  in  $clog2(CHANNELS)  adder channel to measure
- window  in  WINDOW_W  count window length in clock cycles
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- bypass_in  in  WIDTH  per-bit ring bypass mask
- ro_in  in  CHANNELS  asynchronous ring-oscillator outputs
- s_in  in  CHANNELS*WIDTH  adder sums, channel k at [k*WIDTH +: WIDTH]
- adder_a  out  WIDTH  registered operand A to all adders
- adder_b  out  WIDTH  registered operand B to all adders
- bypass_out  out  WIDTH  registered bypass mask
- ro_en  out  CHANNELS  one-hot ring enable
- count  out  CNT_W  edges counted in the last measurement
- s_out  out  WIDTH  captured sum of the selected channel
- busy  out  1  measurement in progress
- done  out  1  one-cycle completion pulse
- overflow  out  1  count saturated during the last measurement

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge) forces:
  - FSM to IDLE
  - adder_a, adder_b, bypass_out, ro_en, count, s_out = 0
  - busy, done, overflow = 0
  - synchroniser and edge-detect flops = 0
- Reset has priority over every other event, including mid-measurement; ro_en drops on the same edge.
- FSM states: IDLE, LOAD, ARM (2 cycles), COUNT, CAPTURE, DONE.
- Timing, with start=1 sampled in IDLE at edge T:
  - T+1 LOAD:
    - adder_a, adder_b, bypass_out latch a_in, b_in, bypass_in.
    - chan_sel and window are latched internally.
    - count and overflow clear to 0; busy=1.
  - T+2, T+3 ARM:
    - ro_en[chan]=1, all other ro_en bits 0.
    - The 2-flop synchroniser plus previous-value flop fill; no edges are counted.
  - T+4 .. T+3+window COUNT:
    - Each cycle with sync=1 and prev=0 increments count.
    - count saturates at 2^CNT_W-1; overflow sets and holds until the next LOAD.
  - T+4+window CAPTURE:
    - ro_en=0.
    - s_out <= s_in slice of the latched channel.
  - T+5+window DONE:
    - done=1 for exactly one cycle; busy=0.
    - Next state IDLE. A start sampled here is ignored; start is accepted from the following cycle.
- window=0: LOAD goes directly to CAPTURE. ro_en is never asserted; done at T+3; count=0.
- chan_sel >= CHANNELS is latched as channel 0.
- start outside IDLE is ignored; inputs other than ro_in and s_in are don't-care after LOAD.
- Only the latched channel's ro_in is synchronised and counted; edges on other channels are ignored.
- count, s_out and overflow hold their values until the next LOAD or reset.

Optional Feature:
- INSTR_ADDER_FORMAL_EN defined: embedded assertions and covers are compiled in:
  - ro_en is one-hot-or-zero.
  - done is never high on two consecutive cycles.
  - busy and done are never both high.
  - count never decreases within a measurement.
  - overflow implies count is all ones.
  - cover: done with count > 0.
  - cover: done with overflow=1.
- Undefined: no assertions or covers; RTL behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> every output 0; ro_en=0 throughout.
- chan_sel=1, window=60, ro_in[1] toggling every 3 clocks (period 6), other ro_in also toggling -> done at T+65, count=10, overflow=0, ro_en=4'b0010 during ARM/COUNT only.
- CNT_W=4, ro_in[0] toggling every clock (period 2), window=40 -> count=15, overflow=1, done one cycle.
- window=0, chan_sel=2 -> done at T+3, count=0, ro_en never high.
- Bench models adders as s_in[k]=adder_a+adder_b; a_in=0xFFFFFFFF, b_in=1, chan_sel=3, window=8 -> adder_a=0xFFFFFFFF, s_out=0x00000000; second run with a_in=5, b_in=7 -> s_out=0x0000000C.
- Mid-COUNT: assert wb_rst_i for 1 cycle; also pulse start while busy in a separate run -> after reset all outputs 0, no done pulse; the mid-run start is ignored and exactly one done is produced.
